rng_stream_writer: RTL and testbench
====================================

Name: rng_stream_writer

Overview:
Parametrised successor to the single-stream RNG engine. It fills a host-specified virtual-memory region with pseudo-random data. NUM_LANES independent xorshift64 generators are concatenated into each write beat, and bursts are issued with up to MAX_OUTSTANDING writes in flight. It sits behind the per-app AXI master and soft-register slot, and is controlled and monitored entirely over soft registers.

Parameters:
NUM_LANES, 8, xorshift64 lanes per beat; DATA_W = 64*NUM_LANES (512 at default)
BURST_BEATS, 64, beats per full burst (AWLEN = BURST_BEATS-1); power of two, at most 256
MAX_OUTSTANDING, 4, maximum AW bursts issued without a B response, 1..15

Ports:
clk  in  1  user clock
rst  in  1  reset; synchronous, active-high
softreg_req_valid/isWrite/addr/data  in  1/1/32/64  soft-register request
softreg_resp_valid/data  out  1/64  read response
awid_m/awaddr_m/awlen_m/awsize_m  out  16/64/8/3  write address; id fixed 0, size = log2(DATA_W/8)
awvalid_m/awready_m  out/in  1/1  AW handshake
wdata_m/wstrb_m/wlast_m  out  DATA_W/DATA_W/8/1  write data; strb all ones
wvalid_m/wready_m  out/in  1/1  W handshake
bid_m/bresp_m/bvalid_m/bready_m  in/in/in/out  16/2/1/1  write response; bready_m is constant 1
arvalid_m/rready_m  out  1/1  held at 0 and 1 respectively; other ar* outputs are 0; r*/arready inputs ignored

Behaviour:
- Registers (byte addr): 0x00 BASE; 0x08 LEN_BEATS; 0x10 SEED; 0x18 write=start / read=STATUS {bit0 busy, bit1 done, bit2 error}; 0x20 BEATS_DONE; 0x28 CHECKSUM (see feature).
- Reads respond exactly 1 cycle after the request; unmapped addresses read 0. Writes to 0x00–0x10 while busy are ignored.
- Reset: all outputs valid-low; BASE, LEN, SEED, counters and status are 0; FSM goes to IDLE. Reset mid-run abandons in-flight bursts with no drain.
- FSM:
  - IDLE -> SEED on a write to 0x18 with LEN ≠ 0. Start with LEN = 0 sets done immediately and stays in IDLE.
  - SEED: 1 cycle. lane i = SEED ^ ((i+1)*64'h9E3779B97F4A7C15). A zero result is replaced by 64'h1.
  - SEED -> RUN.
  - RUN -> DRAIN when the last W beat is accepted.
  - DRAIN -> DONE when the outstanding count is 0.
  - DONE -> IDLE after 1 cycle. On that transition busy clears and done sets. done clears on the next start.
- AW issue: issue while bursts remain and outstanding < MAX_OUTSTANDING. Address = BASE + burst_idx*BURST_BEATS*(DATA_W/8). awlen = min(BURST_BEATS, remaining)-1. awvalid holds until awready, with payload stable.
- W stream: never runs ahead of issued AW; the W-ready burst count must exceed 0. wdata = {lane[N-1],…,lane[0]}. Every lane advances (x^=x<<13; x^=x>>7; x^=x<<17) only on wvalid&&wready. wlast on the final beat of each burst.
- Outstanding counter: +1 on AW handshake, -1 on bvalid. A simultaneous AW handshake and bvalid leave it unchanged. It never exceeds MAX_OUTSTANDING.
- bresp ≠ 0 sets the error bit, which is sticky until the next start. The transfer still completes.
- BEATS_DONE increments per accepted W beat. Widths: 64-bit byte arithmetic; the beat counter wraps only above 2^64 (no special handling).

Optional Feature:
RNG_CHECKSUM_EN: when defined, CHECKSUM ^= fold64(wdata), the XOR of the 64-bit lanes, on every accepted beat. It clears on start. When undefined, 0x28 reads 0 and no accumulator logic exists.

Decomposition:
- Package rng_pkg: register address constants, STATUS bit indices, golden constant, state enum.
- Sub-module xorshift64_lane (seed load, advance enable, 64-bit state out), instantiated NUM_LANES times via generate.

Test Plan:
- SEED=1, LEN=1, BASE=0x1000: one AW with awlen=0 at 0x1000; wdata lane0 = xorshift(seed0) (compute the expected value with a reference model); STATUS=0b010 after bvalid.
- LEN=130, BURST_BEATS=64: three AWs with awlen 63, 63, 1 at BASE, +0x1000, +0x2000; wlast on beats 63, 127, 129; BEATS_DONE=130.
- awready high, bvalid withheld, LEN=640: exactly 4 AWs issued, then none until a bvalid arrives; busy stays 1.
- bresp=2'b10 on burst 2 of 3: remaining bursts still complete; STATUS=0b110.
- wready toggled pseudo-randomly: wdata stays stable while stalled; the sequence matches the model; with RNG_CHECKSUM_EN, CHECKSUM equals the model's fold.
- rst asserted mid-RUN for 1 cycle: next cycle awvalid=wvalid=0 and STATUS=0; a subsequent start runs cleanly.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared constants, FSM states and lane seeding for the RNG stream writer.
package rng_pkg;
  localparam logic [31:0] REG_BASE  = 32'h00;
  localparam logic [31:0] REG_LEN   = 32'h08;
  localparam logic [31:0] REG_SEED  = 32'h10;
  localparam logic [31:0] REG_CTRL  = 32'h18;
  localparam logic [31:0] REG_BEATS = 32'h20;
  localparam logic [31:0] REG_CSUM  = 32'h28;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;

  typedef enum logic [2:0] {S_IDLE, S_SEED, S_RUN, S_DRAIN, S_DONE} state_e;

  // xorshift has an all-zero fixed point, so a zero seed is nudged to 1
  function automatic logic [63:0] lane_seed(logic [63:0] seed, int unsigned idx);
    logic [63:0] s;
    s = seed ^ (64'(idx + 1) * GOLDEN);
    return (s == '0) ? 64'h1 : s;
  endfunction
endpackage

// File: rtl/rng_stream_writer_if.sv
// Soft-register slot plus AXI write master bundle; master = writer, slave = host/memory.
interface rng_stream_writer_if #(parameter int DATA_W = 512);
  logic              softreg_req_valid, softreg_req_isWrite;
  logic [31:0]       softreg_req_addr;
  logic [63:0]       softreg_req_data;
  logic              softreg_resp_valid;
  logic [63:0]       softreg_resp_data;
  logic [15:0]       awid_m;
  logic [63:0]       awaddr_m;
  logic [7:0]        awlen_m;
  logic [2:0]        awsize_m;
  logic              awvalid_m, awready_m;
  logic [DATA_W-1:0] wdata_m;
  logic [DATA_W/8-1:0] wstrb_m;
  logic              wlast_m, wvalid_m, wready_m;
  logic [15:0]       bid_m;
  logic [1:0]        bresp_m;
  logic              bvalid_m, bready_m;
  logic [15:0]       arid_m;
  logic [63:0]       araddr_m;
  logic [7:0]        arlen_m;
  logic [2:0]        arsize_m;
  logic              arvalid_m, rready_m;

  modport master (
    input  softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
    output softreg_resp_valid, softreg_resp_data,
    output awid_m, awaddr_m, awlen_m, awsize_m, awvalid_m, input awready_m,
    output wdata_m, wstrb_m, wlast_m, wvalid_m, input wready_m,
    input  bid_m, bresp_m, bvalid_m, output bready_m,
    output arid_m, araddr_m, arlen_m, arsize_m, arvalid_m, rready_m
  );
  modport slave (
    output softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
    input  softreg_resp_valid, softreg_resp_data,
    input  awid_m, awaddr_m, awlen_m, awsize_m, awvalid_m, output awready_m,
    input  wdata_m, wstrb_m, wlast_m, wvalid_m, output wready_m,
    output bid_m, bresp_m, bvalid_m, input bready_m,
    input  arid_m, araddr_m, arlen_m, arsize_m, arvalid_m, rready_m
  );
endinterface

// File: rtl/rng_stream_writer_lane.sv
// One xorshift64 generator: load a seed, or advance one step when enabled.
module xorshift64_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [63:0] seed_i,
  output logic [63:0] state_o
);
  logic [63:0] state_q, state_d, t0, t1;

  always_comb begin
    t0      = state_q ^ (state_q << 13);
    t1      = t0 ^ (t0 >> 7);
    state_d = state_q;
    if (load_i)     state_d = seed_i;
    else if (adv_i) state_d = t1 ^ (t1 << 17);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  assign state_o = state_q;
endmodule

// File: rtl/rng_stream_writer.sv
// Fills BASE..BASE+LEN beats with NUM_LANES xorshift64 streams over AXI writes.
// Optional RNG_CHECKSUM_EN adds an XOR-fold accumulator readable at 0x28.
module rng_stream_writer
  import rng_pkg::*;
#(
  parameter int NUM_LANES       = 8,
  parameter int BURST_BEATS     = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clk,
  input logic rst,
  rng_stream_writer_if.master bus
);
  localparam int          BEAT_BYTES  = 8 * NUM_LANES;
  localparam logic [63:0] BURST_BYTES = 64'(BURST_BEATS * BEAT_BYTES);
  localparam logic [63:0] BURST_LEN   = 64'(BURST_BEATS);

  state_e      state_q;
  logic [63:0] base_q, len_q, seed_q, beats_q, aw_rem_q, w_rem_q, next_addr_q, awaddr_q;
  logic [63:0] rd_data, resp_data_q;
  logic [7:0]  awlen_q, wbeat_q;
  logic [3:0]  outs_q, wbursts_q;
  logic        awvalid_q, busy_q, done_q, err_q, resp_valid_q;
  logic        sr_wr, start, aw_hs, wvalid, w_hs, wlast, aw_go, unused_bid;
  logic [NUM_LANES-1:0][63:0] lane;

  assign sr_wr  = bus.softreg_req_valid && bus.softreg_req_isWrite;
  assign start  = sr_wr && (bus.softreg_req_addr == REG_CTRL) && (state_q == S_IDLE);
  assign aw_hs  = awvalid_q && bus.awready_m;
  // W may only flow for bursts whose address has already been accepted
  assign wvalid = (state_q == S_RUN) && (wbursts_q != 4'd0);
  assign w_hs   = wvalid && bus.wready_m;
  assign wlast  = (wbeat_q == 8'(BURST_BEATS - 1)) || (w_rem_q == 64'd1);
  assign aw_go  = (state_q == S_RUN) && !awvalid_q && (aw_rem_q != '0) &&
                  (outs_q < 4'(MAX_OUTSTANDING));
  assign unused_bid = ^bus.bid_m;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    xorshift64_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .load_i (state_q == S_SEED),
      .adv_i  (w_hs),
      .seed_i (lane_seed(seed_q, i)),
      .state_o(lane[i])
    );
  end

`ifdef RNG_CHECKSUM_EN
  logic [63:0] csum_q, fold;
  always_comb begin
    fold = '0;
    for (int i = 0; i < NUM_LANES; i++) fold = fold ^ lane[i];
  end
  always_ff @(posedge clk) begin
    if (rst || start) csum_q <= '0;
    else if (w_hs)    csum_q <= csum_q ^ fold;
  end
`endif

  always_comb begin
    rd_data = '0;
    case (bus.softreg_req_addr)
      REG_BASE:  rd_data = base_q;
      REG_LEN:   rd_data = len_q;
      REG_SEED:  rd_data = seed_q;
      REG_CTRL: begin
        rd_data[ST_BUSY] = busy_q;
        rd_data[ST_DONE] = done_q;
        rd_data[ST_ERR]  = err_q;
      end
      REG_BEATS: rd_data = beats_q;
`ifdef RNG_CHECKSUM_EN
      REG_CSUM:  rd_data = csum_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      {base_q, len_q, seed_q, beats_q, aw_rem_q, w_rem_q, next_addr_q, awaddr_q} <= '0;
      {awlen_q, wbeat_q, outs_q, wbursts_q} <= '0;
      {awvalid_q, busy_q, done_q, err_q, resp_valid_q} <= '0;
      resp_data_q <= '0;
    end else begin
      resp_valid_q <= bus.softreg_req_valid && !bus.softreg_req_isWrite;
      resp_data_q  <= rd_data;
      if (sr_wr && !busy_q) begin
        if (bus.softreg_req_addr == REG_BASE) base_q <= bus.softreg_req_data;
        if (bus.softreg_req_addr == REG_LEN)  len_q  <= bus.softreg_req_data;
        if (bus.softreg_req_addr == REG_SEED) seed_q <= bus.softreg_req_data;
      end
      if (bus.bvalid_m && bus.bresp_m != 2'b00) err_q <= 1'b1;

      if (aw_hs && !bus.bvalid_m)                      outs_q <= outs_q + 4'd1;
      else if (!aw_hs && bus.bvalid_m && outs_q != 0)  outs_q <= outs_q - 4'd1;
      if (aw_hs && !(w_hs && wlast))                   wbursts_q <= wbursts_q + 4'd1;
      else if (!aw_hs && w_hs && wlast)                wbursts_q <= wbursts_q - 4'd1;

      if (aw_hs) awvalid_q <= 1'b0;
      if (aw_go) begin
        awvalid_q   <= 1'b1;
        awaddr_q    <= next_addr_q;
        next_addr_q <= next_addr_q + BURST_BYTES;
        if (aw_rem_q >= BURST_LEN) begin
          awlen_q  <= 8'(BURST_BEATS - 1);
          aw_rem_q <= aw_rem_q - BURST_LEN;
        end else begin
          awlen_q  <= aw_rem_q[7:0] - 8'd1;
          aw_rem_q <= '0;
        end
      end

      if (w_hs) begin
        beats_q <= beats_q + 64'd1;
        w_rem_q <= w_rem_q - 64'd1;
        wbeat_q <= wlast ? 8'd0 : wbeat_q + 8'd1;
      end

      case (state_q)
        S_IDLE: if (start) begin
          done_q  <= (len_q == '0);
          err_q   <= 1'b0;
          beats_q <= '0;
          if (len_q != '0) begin
            busy_q  <= 1'b1;
            state_q <= S_SEED;
          end
        end
        S_SEED: begin
          aw_rem_q    <= len_q;
          w_rem_q     <= len_q;
          next_addr_q <= base_q;
          wbeat_q     <= '0;
          state_q     <= S_RUN;
        end
        S_RUN:   if (w_hs && w_rem_q == 64'd1) state_q <= S_DRAIN;
        S_DRAIN: if (outs_q == 4'd0) state_q <= S_DONE;
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.softreg_resp_valid = resp_valid_q;
  assign bus.softreg_resp_data  = resp_data_q;
  assign bus.awid_m    = '0;
  assign bus.awaddr_m  = awaddr_q;
  assign bus.awlen_m   = awlen_q;
  assign bus.awsize_m  = 3'($clog2(BEAT_BYTES));
  assign bus.awvalid_m = awvalid_q;
  assign bus.wdata_m   = lane;
  assign bus.wstrb_m   = '1;
  assign bus.wlast_m   = wlast;
  assign bus.wvalid_m  = wvalid;
  assign bus.bready_m  = 1'b1;
  assign bus.arid_m    = '0;
  assign bus.araddr_m  = '0;
  assign bus.arlen_m   = '0;
  assign bus.arsize_m  = '0;
  assign bus.arvalid_m = 1'b0;
  assign bus.rready_m  = 1'b1;
endmodule

// File: tb/tb_rng_stream_writer.sv
// Randomized bench for rng_stream_writer: memory slave plus stream/burst reference model.
module tb_rng_stream_writer;
  localparam int NL = 8, BB = 64, MO = 4, DW = 512;
  localparam logic [31:0] A_BASE = 32'h00, A_LEN = 32'h08, A_SEED = 32'h10,
                          A_CTRL = 32'h18, A_BEATS = 32'h20, A_CSUM = 32'h28;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  rng_stream_writer_if #(.DATA_W(DW)) bus();
  rng_stream_writer #(.NUM_LANES(NL), .BURST_BEATS(BB), .MAX_OUTSTANDING(MO))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, failures = 0;
  logic [63:0] m_lane [NL];
  logic [63:0] m_base, m_len, m_csum, exp_len;
  logic [DW-1:0] exp_w, prev_data;
  int aw_cnt, w_cnt, b_cnt, outs_tb, err_burst, aw_pct, w_pct, bidx;
  bit hold_b, prev_stall, exp_last;
  int bq[$];

  task automatic chk(string tag, logic [511:0] got, logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] xs(logic [63:0] x);
    x = x ^ (x << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  function automatic logic [63:0] seed_of(logic [63:0] s, int i);
    logic [63:0] v;
    v = s ^ (64'(i + 1) * 64'h9E3779B97F4A7C15);
    return (v == 0) ? 64'd1 : v;
  endfunction

  // Memory slave: random readies, checks every AW/W against the model, returns B later.
  initial begin
    bus.awready_m = 0; bus.wready_m = 0; bus.bvalid_m = 0; bus.bresp_m = 0; bus.bid_m = 0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        bq.delete(); outs_tb = 0; bus.bvalid_m = 0; prev_stall = 0;
        continue;
      end
      if (prev_stall) begin
        chk("w_hold_valid", bus.wvalid_m, 1);
        chk("w_hold_data", bus.wdata_m, prev_data);
      end
      if (!hold_b && bq.size() > 0 && $urandom_range(1) == 1) begin
        bidx = bq.pop_front();
        bus.bvalid_m = 1;
        bus.bresp_m  = (bidx == err_burst) ? 2'b10 : 2'b00;
        b_cnt++; outs_tb--;
      end else begin
        bus.bvalid_m = 0; bus.bresp_m = 0;
      end
      bus.awready_m = ($urandom_range(99) < aw_pct);
      bus.wready_m  = ($urandom_range(99) < w_pct);
      if (bus.awvalid_m && bus.awready_m) begin
        exp_len = m_len - 64'(aw_cnt * BB);
        exp_len = (exp_len >= BB) ? 64'(BB - 1) : exp_len - 1;
        chk("aw_addr", bus.awaddr_m, m_base + 64'(aw_cnt) * 64'(BB * DW / 8));
        chk("aw_len", bus.awlen_m, exp_len);
        chk("aw_size_id", {bus.awsize_m, bus.awid_m}, {3'd6, 16'd0});
        aw_cnt++; outs_tb++;
        chk("outs_max", outs_tb <= MO, 1);
      end
      if (bus.wvalid_m && bus.wready_m) begin
        chk("w_extra", 64'(w_cnt) < m_len, 1);
        chk("w_order", (w_cnt / BB) < aw_cnt, 1);
        for (int i = 0; i < NL; i++) exp_w[i*64 +: 64] = m_lane[i];
        exp_last = (w_cnt % BB == BB - 1) || (64'(w_cnt) == m_len - 1);
        chk("w_data", bus.wdata_m, exp_w);
        chk("w_last", bus.wlast_m, exp_last);
        chk("w_strb", bus.wstrb_m, {64{1'b1}});
        for (int i = 0; i < NL; i++) begin
          m_csum ^= m_lane[i];
          m_lane[i] = xs(m_lane[i]);
        end
        if (exp_last) bq.push_back(w_cnt / BB);
        w_cnt++;
      end
      prev_stall = bus.wvalid_m && !bus.wready_m;
      prev_data  = bus.wdata_m;
    end
  end

  task automatic sr_write(logic [31:0] a, logic [63:0] d);
    @(negedge clk);
    bus.softreg_req_valid = 1; bus.softreg_req_isWrite = 1;
    bus.softreg_req_addr = a; bus.softreg_req_data = d;
    @(negedge clk);
    bus.softreg_req_valid = 0; bus.softreg_req_isWrite = 0;
  endtask

  task automatic sr_read(logic [31:0] a, output logic [63:0] d);
    @(negedge clk);
    bus.softreg_req_valid = 1; bus.softreg_req_isWrite = 0; bus.softreg_req_addr = a;
    @(negedge clk);
    bus.softreg_req_valid = 0;
    chk("rd_latency", bus.softreg_resp_valid, 1);
    d = bus.softreg_resp_data;
  endtask

  task automatic start_run(logic [63:0] base, logic [63:0] len, logic [63:0] seed,
                           int eb, int awp, int wp);
    m_base = base; m_len = len; err_burst = eb; aw_pct = awp; w_pct = wp;
    for (int i = 0; i < NL; i++) m_lane[i] = seed_of(seed, i);
    m_csum = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    sr_write(A_BASE, base);
    sr_write(A_LEN, len);
    sr_write(A_SEED, seed);
    sr_write(A_CTRL, 64'd1);
  endtask

  task automatic finish_run(string tag, logic [2:0] exp_st);
    logic [63:0] v;
    int nb;
    v = 64'd1;
    for (int c = 0; c < 8000 && v[0]; c++) sr_read(A_CTRL, v);
    chk({tag, "_status"}, v, 64'(exp_st));
    sr_read(A_BEATS, v);
    chk({tag, "_beats"}, v, m_len);
    nb = int'((m_len + BB - 1) / BB);
    chk({tag, "_aw_cnt"}, aw_cnt, nb);
    chk({tag, "_w_cnt"}, w_cnt, m_len);
    chk({tag, "_b_cnt"}, b_cnt, nb);
    sr_read(A_CSUM, v);
`ifdef RNG_CHECKSUM_EN
    chk({tag, "_csum"}, v, m_csum);
`else
    chk({tag, "_csum"}, v, 0);
`endif
  endtask

  initial begin
    logic [63:0] v;
    bus.softreg_req_valid = 0; bus.softreg_req_isWrite = 0;
    bus.softreg_req_addr = 0; bus.softreg_req_data = 0;
    hold_b = 0; aw_pct = 100; w_pct = 100; err_burst = -1; m_len = 0; m_base = 0;
    repeat (3) @(negedge clk);
    rst = 0;

    chk("rst_awvalid", bus.awvalid_m, 0);
    chk("rst_wvalid", bus.wvalid_m, 0);
    chk("rst_respvalid", bus.softreg_resp_valid, 0);
    chk("rst_fixed", {bus.bready_m, bus.arvalid_m, bus.rready_m}, 3'b101);
    sr_read(A_CTRL, v);  chk("rst_status", v, 0);
    sr_read(A_BASE, v);  chk("rst_base", v, 0);
    sr_read(A_LEN, v);   chk("rst_len", v, 0);
    sr_read(A_BEATS, v); chk("rst_beats", v, 0);
    sr_read(32'h30, v);  chk("unmapped", v, 0);

    start_run(64'h1000, 1, 1, -1, 100, 100);
    finish_run("single", 3'b010);

    start_run(64'h5000, 0, 64'h77, -1, 100, 100);
    finish_run("len0", 3'b010);

    start_run(64'h20000, 130, {$urandom, $urandom}, -1, 100, 100);
    sr_write(A_BASE, 64'hDEAD_0000);
    finish_run("len130", 3'b010);
    sr_read(A_BASE, v); chk("busy_write_ignored", v, 64'h20000);

    hold_b = 1;
    start_run(64'h40000, 640, {$urandom, $urandom}, -1, 100, 100);
    repeat (600) @(negedge clk);
    chk("hold_aw_cnt", aw_cnt, MO);
    chk("hold_awvalid", bus.awvalid_m, 0);
    sr_read(A_CTRL, v); chk("hold_busy", v[0], 1);
    hold_b = 0;
    finish_run("hold", 3'b010);

    start_run(64'h80000, 130, {$urandom, $urandom}, 1, 70, 70);
    finish_run("bresp_err", 3'b110);

    for (int t = 0; t < 3; t++) begin
      start_run({$urandom, $urandom_range(255), 12'h0}, 64'($urandom_range(1, 300)),
                {$urandom, $urandom}, -1, $urandom_range(30, 100), $urandom_range(20, 90));
      finish_run("random", 3'b010);
    end

    start_run(64'hC0000, 640, {$urandom, $urandom}, -1, 100, 60);
    repeat (100) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_awvalid", bus.awvalid_m, 0);
    chk("midrst_wvalid", bus.wvalid_m, 0);
    sr_read(A_CTRL, v);  chk("midrst_status", v, 0);
    sr_read(A_BEATS, v); chk("midrst_beats", v, 0);
    start_run(64'hE0000, 200, {$urandom, $urandom}, -1, 80, 50);
    finish_run("after_rst", 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
